// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction-cache responder and its tag RAM.
//   state_e       : responder FSM states (IDLE, FILL)
//   NOP           : instruction returned for misaligned fetches (addi x0,x0,0)
//   LINES_DEFAULT : default number of one-word direct-mapped lines
// ---------------------------------------------------------------------------
package icache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam logic [31:0] NOP           = 32'h0000_0013;
    localparam int          LINES_DEFAULT = 16;

endpackage

// File: rtl/icache_tagram.sv
// ---------------------------------------------------------------------------
// icache_tagram
// Direct-mapped tag / valid / data storage, one 32-bit word per line.
//   clk, rst          : clock, asynchronous active-low reset (valid bits only)
//   rd_idx, rd_tag    : lookup index and tag
//   hit               : combinational tag match against a valid line
//   rd_en             : capture the line data of rd_idx at the clock edge
//   rd_data           : registered read data (1-cycle read), held while rd_en=0
//   wr_en, wr_idx,
//   wr_tag, wr_data   : synchronous line write, sets the line's valid bit
//   clear             : synchronous clear of every valid bit (wins over wr_en)
// ---------------------------------------------------------------------------
module icache_tagram
    import icache_pkg::*;
#(
    parameter int LINES = LINES_DEFAULT,
    parameter int IW    = $clog2(LINES),
    parameter int TW    = 30 - IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] rd_idx,
    input  logic [TW-1:0] rd_tag,
    output logic          hit,
    input  logic          rd_en,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [TW-1:0] wr_tag,
    input  logic [31:0]   wr_data,
    input  logic          clear
);

    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= data_q[rd_idx];
        end
    end

    assign hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

endmodule

// File: rtl/icache_responder.sv
// ---------------------------------------------------------------------------
// icache_responder
// One-word-per-line direct-mapped instruction cache between fetch and memory.
//   clk, rst             : clock, asynchronous active-low reset
//   fetch_req/fetch_addr : fetch request and byte address
//   fetch_ready          : request accepted this cycle when fetch_req=1
//   stall                : decode stall, holds a presented instruction
//   flush                : invalidate every line
//   icache_instr/
//   instr_valid          : response to fetch, one cycle after acceptance
//   mem_req/mem_addr     : refill request and word-aligned address
//   mem_ack/mem_data     : refill completion and data
//   dbg_state            : current FSM state
//
// Handshakes: fetch is accepted on a cycle where fetch_req and fetch_ready are
// both 1; fetch_ready never depends on fetch_req. A refill request holds
// mem_req=1 and a stable mem_addr until the cycle mem_ack=1; mem_ack outside a
// refill is ignored.
// ---------------------------------------------------------------------------
module icache_responder
    import icache_pkg::*;
#(
    parameter int LINES = LINES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        stall,
    input  logic        flush,
    output logic        fetch_ready,
    output logic [31:0] icache_instr,
    output logic        instr_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output state_e      dbg_state
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;

    state_e      state_q, state_d;
    logic        ready_en_q;     // low until the first edge after reset
    logic        instr_valid_q;
    logic        sel_ram_q;      // response comes from the tag RAM read port
    logic        fill_keep_q;    // cleared if a flush lands during the refill
    logic [31:0] resp_q;         // NOP or refill word
    logic [31:0] fill_addr_q;
    logic [31:0] ram_data;
    logic        ram_hit;
    logic        accept;
    logic        aligned;
    logic        lookup_hit;
    logic        lookup_miss;
    logic        fill_done;
    logic        fill_wr;

    assign aligned     = (fetch_addr[1:0] == 2'b00);
    assign fetch_ready = ready_en_q && (state_q == IDLE) && !flush
                         && !(instr_valid_q && stall);
    assign accept      = fetch_req && fetch_ready;
    assign lookup_hit  = accept && aligned && ram_hit;
    assign lookup_miss = accept && aligned && !ram_hit;
    assign fill_done   = (state_q == FILL) && mem_ack;
    // A flush in the ack cycle also keeps the line invalid.
    assign fill_wr     = fill_done && fill_keep_q && !flush;

    icache_tagram #(
        .LINES (LINES),
        .IW    (IW),
        .TW    (TW)
    ) u_tagram (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (fetch_addr[IW+1:2]),
        .rd_tag  (fetch_addr[31:IW+2]),
        .hit     (ram_hit),
        .rd_en   (lookup_hit),
        .rd_data (ram_data),
        .wr_en   (fill_wr),
        .wr_idx  (fill_addr_q[IW+1:2]),
        .wr_tag  (fill_addr_q[31:IW+2]),
        .wr_data (mem_data),
        .clear   (flush)
    );

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (lookup_miss) state_d = FILL;
            end
            FILL: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            ready_en_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            sel_ram_q     <= 1'b0;
            fill_keep_q   <= 1'b0;
            resp_q        <= '0;
            fill_addr_q   <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            if (accept) begin
                if (!aligned) begin
                    instr_valid_q <= 1'b1;
                    resp_q        <= NOP;
                    sel_ram_q     <= 1'b0;
                end else if (ram_hit) begin
                    instr_valid_q <= 1'b1;
                    sel_ram_q     <= 1'b1;
                end else begin
                    instr_valid_q <= 1'b0;
                    fill_addr_q   <= {fetch_addr[31:2], 2'b00};
                    fill_keep_q   <= 1'b1;
                end
            end else if (fill_done) begin
                instr_valid_q <= 1'b1;
                resp_q        <= mem_data;
                sel_ram_q     <= 1'b0;
            end else if (!(instr_valid_q && stall)) begin
                instr_valid_q <= 1'b0;
            end
            if ((state_q == FILL) && flush) begin
                fill_keep_q <= 1'b0;
            end
        end
    end

    // The RAM read register only moves on a hit, so it holds under stall too.
    assign icache_instr = sel_ram_q ? ram_data : resp_q;
    assign instr_valid  = instr_valid_q;
    assign mem_addr     = fill_addr_q;
    assign dbg_state    = state_q;

endmodule
